// File: rtl/stream_demultiplexer.sv
// stream_demultiplexer: routes one input stream to a one-hot selected, independently stalled output slot.
// Define STREAM_DEMUX_BROADCAST_EN to accept multi-hot selects as broadcast; otherwise they are dropped and counted.
module stream_demultiplexer #(
    parameter int num_outputs = 4,
    parameter int bit_width   = 8,
    parameter int count_width = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [bit_width-1:0]                   in_data,
    input  logic [num_outputs-1:0]                 in_sel,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [num_outputs-1:0][bit_width-1:0]  out_data,
    output logic [num_outputs-1:0]                 out_valid,
    input  logic [num_outputs-1:0]                 out_ready,
    output logic                                   drop_pulse,
    output logic [count_width-1:0]                 drop_count
);
    logic [num_outputs-1:0] free;
    logic [num_outputs-1:0] load;
    logic                   legal;
    logic                   drop;

    always_comb begin
        free = ~out_valid | out_ready;
`ifdef STREAM_DEMUX_BROADCAST_EN
        legal = |in_sel;
`else
        legal = $countones(in_sel) == 1;
`endif
        // illegal beats are always accepted so they can be discarded
        in_ready = !legal || &(free | ~in_sel);
        load = (in_valid && in_ready && legal) ? in_sel : '0;
        drop = in_valid && !legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= '0;
            out_data   <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            out_valid <= load | (out_valid & ~out_ready);
            for (int j = 0; j < num_outputs; j++)
                if (load[j]) out_data[j] <= in_data;
            drop_pulse <= drop;
            if (drop && !(&drop_count)) drop_count <= drop_count + count_width'(1);
        end
    end
endmodule

// File: tb/tb_stream_demultiplexer.sv
// tb_stream_demultiplexer: directed stimulus against a slot-occupancy reference model, plus literal spot checks.
module tb_stream_demultiplexer;
    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data;
    logic [3:0]       in_sel;
    logic             in_valid;
    logic             in_ready, in_ready2;
    logic [3:0][7:0]  out_data, out_data2;
    logic [3:0]       out_valid, out_valid2;
    logic [3:0]       out_ready;
    logic             drop_pulse, drop_pulse2;
    logic [15:0]      drop_count;
    logic [1:0]       drop_count2;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef STREAM_DEMUX_BROADCAST_EN
    localparam int total_drops = 4;
`else
    localparam int total_drops = 5;
`endif

    stream_demultiplexer #(.num_outputs(4), .bit_width(8), .count_width(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    stream_demultiplexer #(.num_outputs(4), .bit_width(8), .count_width(2)) dut_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .drop_pulse(drop_pulse2), .drop_count(drop_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: each slot either holds a beat or is empty
    logic       m_full[4];
    logic [7:0] m_data[4];
    logic       m_pulse;
    int         m_cnt, m_cnt2;

    function automatic bit m_legal();
`ifdef STREAM_DEMUX_BROADCAST_EN
        return in_sel != 4'b0000;
`else
        return $countones(in_sel) == 1;
`endif
    endfunction

    function automatic bit m_ready();
        int blocked = 0;
        for (int j = 0; j < 4; j++)
            if (in_sel[j] && m_full[j] && !out_ready[j]) blocked++;
        return !m_legal() || blocked == 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 4; j++) begin
                m_full[j] = 1'b0;
                m_data[j] = 8'h00;
            end
            m_pulse = 1'b0;
            m_cnt   = 0;
            m_cnt2  = 0;
        end else begin
            bit take, ok;
            take = in_valid && m_ready();
            ok   = m_legal();
            for (int j = 0; j < 4; j++) begin
                if (take && ok && in_sel[j]) begin
                    m_full[j] = 1'b1;
                    m_data[j] = in_data;
                end else if (out_ready[j]) begin
                    m_full[j] = 1'b0;
                end
            end
            m_pulse = take && !ok;
            if (m_pulse) begin
                m_cnt  = (m_cnt  == 65535) ? 65535 : m_cnt + 1;
                m_cnt2 = (m_cnt2 == 3) ? 3 : m_cnt2 + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, m_ready());
        for (int j = 0; j < 4; j++) begin
            check("out_valid", out_valid[j], m_full[j]);
            check("out_data", out_data[j], m_data[j]);
        end
        check("drop_pulse", drop_pulse, m_pulse);
        check("drop_count", drop_count, m_cnt);
        check("drop_count_sat", drop_count2, m_cnt2);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 4'b0000; in_data = 8'h00; out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_valid", out_valid, 4'b0000);
        check("reset_count", drop_count, 16'd0);

        // basic route and sustained throughput to slot 2
        #1 in_sel = 4'b0100; in_data = 8'hA5; in_valid = 1'b1;
        step();
        check("route_valid", out_valid, 4'b0100);
        check("route_data", out_data[2], 8'hA5);
        for (int i = 0; i < 8; i++) begin
            in_data = 8'h10 + 8'(i);
            step();
            check("stream_data", out_data[2], 8'h10 + 8'(i));
            check("stream_valid", out_valid[2], 1'b1);
        end
        in_valid = 1'b0;
        step();

        // backpressure on slot 1, then redirect to slot 0
        out_ready = 4'b1101; in_sel = 4'b0010; in_data = 8'h11; in_valid = 1'b1;
        step();
        in_data = 8'h22;
        #1 check("bp_ready", in_ready, 1'b0);
        step();
        check("bp_hold", out_data[1], 8'h11);
        in_sel = 4'b0001; in_data = 8'h33;
        #1 check("redirect_ready", in_ready, 1'b1);
        step();
        check("redirect_data", out_data[0], 8'h33);
        check("redirect_keep", out_data[1], 8'h11);

        // simultaneous drain and load on slot 3
        out_ready = 4'b0101; in_sel = 4'b1000; in_data = 8'h44;
        step();
        out_ready = 4'b1111; in_data = 8'h3C;
        #1 check("dl_ready", in_ready, 1'b1);
        step();
        check("dl_valid", out_valid[3], 1'b1);
        check("dl_data", out_data[3], 8'h3C);
        in_valid = 1'b0;
        step();

        // illegal selects and counter saturation
        in_sel = 4'b0000; in_data = 8'h55; in_valid = 1'b1;
        #1 check("ill_ready", in_ready, 1'b1);
        step();
        check("ill_pulse", drop_pulse, 1'b1);
        check("ill_count1", drop_count, 16'd1);
        check("ill_noslot", out_valid, 4'b0000);
        in_sel = 4'b0011;
        step();
`ifdef STREAM_DEMUX_BROADCAST_EN
        check("bc_pair_valid", out_valid, 4'b0011);
`else
        check("multi_pulse", drop_pulse, 1'b1);
        check("multi_count", drop_count, 16'd2);
`endif
        in_valid = 1'b0;
        step();
        check("pulse_low", drop_pulse, 1'b0);
        in_sel = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
        end
        check("total_drops", drop_count, 16'(total_drops));
        check("sat_count", drop_count2, 2'd3);

`ifdef STREAM_DEMUX_BROADCAST_EN
        out_ready = 4'b0111; in_sel = 4'b1000; in_data = 8'h66; in_valid = 1'b1;
        step();
        in_sel = 4'b1010; in_data = 8'h77;
        #1 check("bc_stall", in_ready, 1'b0);
        step();
        check("bc_no_load", out_valid[1], 1'b0);
        out_ready = 4'b1111;
        #1 check("bc_release", in_ready, 1'b1);
        step();
        check("bc_valid", out_valid & 4'b1010, 4'b1010);
        check("bc_data1", out_data[1], 8'h77);
        check("bc_data3", out_data[3], 8'h77);
        check("bc_count", drop_count, 16'(total_drops));
        in_valid = 1'b0;
        step();
`endif

        // asynchronous reset with slots 1 and 2 occupied
        out_ready = 4'b1001; in_sel = 4'b0010; in_data = 8'h81; in_valid = 1'b1;
        step();
        in_sel = 4'b0100; in_data = 8'h82;
        step();
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 4'b0110);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_valid", out_valid, 4'b0000);
        check("async_data", out_data, 32'h0);
        check("async_count", drop_count, 16'd0);
        check("async_pulse", drop_pulse, 1'b0);
        step();
        rst = 1'b0; out_ready = 4'hF; in_sel = 4'b0001; in_data = 8'h99; in_valid = 1'b1;
        step();
        check("post_reset_data", out_data[0], 8'h99);
        in_valid = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
